tqvp_mac: RTL and testbench

TQVP_MAC -- requirements
Module: tqvp_mac

---
 rtl/tqvp_mac.sv | 184 ++++++++++++++++++
 tb/tb_tqvp_mac.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/tqvp_mac.sv
// tqvp_mac: memory-mapped 16x16 unsigned shift-add multiply-accumulate peripheral.
//
// A 32-bit write to OPS starts a multiply of A=data_in[15:0] by B=data_in[31:16].
// The product is built one bit of B per clock (16 steps). One more edge then adds
// it into the 32-bit accumulator, flags carry-out as sticky ovf and raises done.
//
// Register map (offsets on `address`):
//   0x00 OPS    write only: start operation (32-bit writes only)
//   0x04 ACC    read only : accumulator
//   0x08 STATUS read      : {28'b0, err, ovf, busy, done}; write bit0=1 clears done
//   0x0C CTRL   write only: bit0=1 clears acc/ovf/err/done and aborts any operation
//
// Ports:
//   clk            clock, all state on rising edge
//   rst            asynchronous active-high reset
//   ui_in          input PMOD, not used by this block
//   uo_out         accumulator bits [7:0]
//   address        register offset
//   data_in        write data
//   data_write_n   write size: 11 none, 00 8-bit, 01 16-bit, 10 32-bit
//   data_read_n    read size, same encoding; reads have no side effects
//   data_out       read data
//   data_ready     read complete (always 1)
//   user_interrupt mirrors done
module tqvp_mac (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StAcc
    } state_e;

    localparam logic [5:0] AddrOps    = 6'h00;
    localparam logic [5:0] AddrAcc    = 6'h04;
    localparam logic [5:0] AddrStatus = 6'h08;
    localparam logic [5:0] AddrCtrl   = 6'h0C;

    state_e      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] prod_q, prod_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;
    logic        err_q, err_d;

    logic        busy;
    logic        wr_any;
    logic        wr_ops;
    logic        clr_ctrl;
    logic        clr_done;
    logic [4:0]  step_idx;
    logic [32:0] sum;
    logic        unused_ok;

    assign unused_ok = ^ui_in;

    assign busy     = (state_q != StIdle);
    assign wr_any   = (data_write_n != 2'b11);
    assign wr_ops   = (data_write_n == 2'b10) && (address == AddrOps);
    assign clr_ctrl = wr_any && (address == AddrCtrl) && data_in[0];
    assign clr_done = wr_any && (address == AddrStatus) && data_in[0];
    // Counter runs 16..1 during MUL, so the step index is 0..15.
    assign step_idx = 5'd16 - cnt_q;
    assign sum      = {1'b0, acc_q} + {1'b0, prod_q};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        err_d   = err_q;

        // Clearing done comes first so an ACC-edge set below takes priority.
        if (clr_done) begin
            done_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (wr_ops) begin
                    a_d     = data_in[15:0];
                    b_d     = data_in[31:16];
                    prod_d  = 32'd0;
                    cnt_d   = 5'd16;
                    state_d = StMul;
                end
            end
            StMul: begin
                if (wr_ops) begin
                    err_d = 1'b1;
                end
                if (b_q[0]) begin
                    prod_d = prod_q + ({16'd0, a_q} << step_idx);
                end
                b_d   = b_q >> 1;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = StAcc;
                end
            end
            StAcc: begin
                if (wr_ops) begin
                    err_d = 1'b1;
                end
                acc_d = sum[31:0];
                if (sum[32]) begin
                    ovf_d = 1'b1;
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides everything, including a pending accumulate.
        if (clr_ctrl) begin
            acc_d   = 32'd0;
            ovf_d   = 1'b0;
            err_d   = 1'b0;
            done_d  = 1'b0;
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= 32'd0;
            prod_q  <= 32'd0;
            a_q     <= 16'd0;
            b_q     <= 16'd0;
            cnt_q   <= 5'd0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        data_out = 32'd0;
        if (data_read_n != 2'b11) begin
            case (address)
                AddrAcc:    data_out = acc_q;
                AddrStatus: data_out = {28'd0, err_q, ovf_q, busy, done_q};
                default:    data_out = 32'd0;
            endcase
        end
    end

    assign uo_out         = acc_q[7:0];
    assign data_ready     = 1'b1;
    assign user_interrupt = done_q;

endmodule

// File: tb/tb_tqvp_mac.sv
// Self-checking bench for tqvp_mac. Expected accumulator values are computed and
// queued when an operation is started, then popped and compared when done appears.
module tb_tqvp_mac;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ui_in;
    logic [7:0]  uo_out;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        user_interrupt;

    tqvp_mac dut (
        .clk            (clk),
        .rst            (rst),
        .ui_in          (ui_in),
        .uo_out         (uo_out),
        .address        (address),
        .data_in        (data_in),
        .data_write_n   (data_write_n),
        .data_read_n    (data_read_n),
        .data_out       (data_out),
        .data_ready     (data_ready),
        .user_interrupt (user_interrupt)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] acc_m    = 32'd0;
    logic        ovf_m    = 1'b0;
    logic [31:0] rd;
    int          busy_cycles;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [5:0] addr, input logic [31:0] data,
                             input logic [1:0] size);
        @(negedge clk);
        address      = addr;
        data_in      = data;
        data_write_n = size;
        @(posedge clk);
        #1 data_write_n = 2'b11;
    endtask

    task automatic read_reg(input logic [5:0] addr, output logic [31:0] val);
        address     = addr;
        data_read_n = 2'b10;
        #1 val      = data_out;
        data_read_n = 2'b11;
    endtask

    // Queue the expected accumulator for this operation, then issue the start write.
    task automatic start_op(input logic [31:0] ops);
        logic [31:0] prod;
        logic [32:0] s;
        prod = {16'd0, ops[15:0]} * {16'd0, ops[31:16]};
        s    = {1'b0, acc_m} + {1'b0, prod};
        exp_q.push_back(s[31:0]);
        acc_m = s[31:0];
        if (s[32]) ovf_m = 1'b1;
        bus_write(6'h00, ops, 2'b10);
    endtask

    task automatic model_clear();
        acc_m = 32'd0;
        ovf_m = 1'b0;
    endtask

    // Counts busy cycles seen on falling edges until busy drops (bounded).
    task automatic wait_done(output int cycles);
        logic [31:0] st;
        cycles = 0;
        st     = 32'h2;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            read_reg(6'h08, st);
            if (st[1]) cycles++;
            else break;
        end
        check_eq("op_finished", {31'd0, st[1]}, 32'd0);
    endtask

    task automatic check_result(input string tag);
        logic [31:0] exp;
        logic [31:0] got;
        exp = exp_q.pop_front();
        read_reg(6'h04, got);
        check_eq(tag, got, exp);
        check_eq({tag, "_uo"}, {24'd0, uo_out}, {24'd0, exp[7:0]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        ui_in        = 8'hA5;
        address      = 6'h00;
        data_in      = 32'd0;
        data_write_n = 2'b11;
        data_read_n  = 2'b11;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        read_reg(6'h04, rd);  check_eq("rst_acc", rd, 32'd0);
        read_reg(6'h08, rd);  check_eq("rst_status", rd, 32'd0);
        check_eq("rst_uo", {24'd0, uo_out}, 32'd0);
        check_eq("rst_irq", {31'd0, user_interrupt}, 32'd0);
        check_eq("data_ready", {31'd0, data_ready}, 32'd1);
        read_reg(6'h00, rd);  check_eq("rd_ops_zero", rd, 32'd0);
        read_reg(6'h3C, rd);  check_eq("rd_unmapped_zero", rd, 32'd0);

        // 3 * 5 with latency check
        start_op(32'h0005_0003);
        wait_done(busy_cycles);
        check_eq("latency", busy_cycles, 32'd17);
        check_result("acc_15");
        read_reg(6'h08, rd);  check_eq("status_done", rd, 32'h1);
        check_eq("irq_done", {31'd0, user_interrupt}, 32'd1);

        // Overflow on accumulate
        bus_write(6'h0C, 32'd1, 2'b10);
        model_clear();
        start_op(32'hFFFF_FFFF);
        wait_done(busy_cycles);
        check_result("acc_ff1");
        read_reg(6'h08, rd);  check_eq("status_no_ovf", rd, {28'd0, 1'b0, ovf_m, 2'b01});
        start_op(32'hFFFF_FFFF);
        wait_done(busy_cycles);
        check_result("acc_ff2");
        read_reg(6'h08, rd);  check_eq("status_ovf", rd, {28'd0, 1'b0, ovf_m, 2'b01});

        // Start while busy: err set, original operands still used
        bus_write(6'h0C, 32'd1, 2'b10);
        model_clear();
        start_op(32'h0002_0003);
        repeat (3) @(posedge clk);
        bus_write(6'h00, 32'h0009_0009, 2'b10);
        wait_done(busy_cycles);
        check_result("acc_busy_write");
        read_reg(6'h08, rd);  check_eq("status_err", rd, 32'h9);

        // Narrow writes to OPS never start
        bus_write(6'h00, 32'h0005_0003, 2'b01);
        @(negedge clk);
        read_reg(6'h08, rd);  check_eq("w16_no_start", rd, 32'h9);
        bus_write(6'h00, 32'h0005_0003, 2'b00);
        @(negedge clk);
        read_reg(6'h08, rd);  check_eq("w8_no_start", rd, 32'h9);

        // Abort via CTRL at cycle 8
        start_op(32'h0003_0003);
        repeat (6) @(posedge clk);
        bus_write(6'h0C, 32'd1, 2'b10);
        void'(exp_q.pop_back());
        model_clear();
        @(negedge clk);
        read_reg(6'h08, rd);  check_eq("abort_status", rd, 32'h0);
        read_reg(6'h04, rd);  check_eq("abort_acc", rd, 32'd0);
        repeat (20) @(negedge clk);
        read_reg(6'h08, rd);  check_eq("abort_no_done", rd, 32'h0);
        read_reg(6'h04, rd);  check_eq("abort_acc_late", rd, 32'd0);

        // Done set by ACC beats a same-cycle STATUS clear
        start_op(32'h0004_0004);
        repeat (16) @(posedge clk);
        bus_write(6'h08, 32'd1, 2'b10);
        @(negedge clk);
        read_reg(6'h08, rd);  check_eq("set_wins", rd, 32'h1);
        check_result("acc_16");
        bus_write(6'h08, 32'd1, 2'b10);
        @(negedge clk);
        read_reg(6'h08, rd);  check_eq("done_cleared", rd, 32'h0);
        check_eq("irq_cleared", {31'd0, user_interrupt}, 32'd0);

        // Asynchronous reset mid-MUL
        start_op(32'h0007_0007);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_uo", {24'd0, uo_out}, 32'd0);
        check_eq("arst_irq", {31'd0, user_interrupt}, 32'd0);
        read_reg(6'h08, rd);  check_eq("arst_status", rd, 32'd0);
        read_reg(6'h04, rd);  check_eq("arst_acc", rd, 32'd0);
        exp_q.delete();
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        start_op(32'h0002_0007);
        wait_done(busy_cycles);
        check_eq("latency_after_rst", busy_cycles, 32'd17);
        check_result("acc_14");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
